pipe_stall_ctrl: RTL

- Central pipeline control unit for the 5-stage core; the consumer side of the load-use stall request produced by hazard detection.
- Combines four inputs into per-register enable and valid-in controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB:
  - load-use stall request
  - data-memory busy
  - EX-stage branch redirect
  - instruction-fetch acknowledge
- Owns the stage valid bits, a stale-fetch discard FSM and saturating stall/flush performance counters.

---
 rtl/pipe_stall_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pipe_stall_ctrl.sv
// Pipeline control for the 5-stage core: turns stall, busy, redirect and fetch-ack
// into per-register enables and valid-ins, and owns stage valids, fetch-discard FSM and perf counters.
module pipe_stall_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             hazard_stall,
  input  logic             br_taken,
  input  logic             mem_busy,
  input  logic             if_ack,
  output logic             if_req,
  output logic             pc_en,
  output logic             pc_sel_redirect,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_vin,
  output logic             id_ex_vin,
  output logic             ex_mem_vin,
  output logic             mem_wb_vin,
  output logic             v_id,
  output logic             v_ex,
  output logic             v_mem,
  output logic             v_wb,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {ST_RUN = 1'b0, ST_DROP = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_v_id, r_v_ex, r_v_mem, r_v_wb;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic             w_freeze, w_redirect, w_load_use, w_fetch_ok;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic inc);
    if (inc && (cnt != {CNT_W{1'b1}})) return cnt + CNT_W'(1);
    return cnt;
  endfunction

  // Priority: a frozen MEM stage defers both redirect and load-use until it drains.
  assign w_freeze   = mem_busy & r_v_mem;
  assign w_redirect = br_taken & r_v_ex & ~w_freeze;
  assign w_load_use = hazard_stall & r_v_id & ~w_freeze & ~w_redirect;
  assign w_fetch_ok = if_ack & (r_state == ST_RUN);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_RUN;
    else       r_state <= w_state_nxt;
  end

  // In DROP any ack is the stale response to the pre-redirect PC, so it only releases the FSM.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:  if (w_redirect && !if_ack) w_state_nxt = ST_DROP;
      ST_DROP: if (if_ack)                w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    if_req          = rstn;
    pc_en           = 1'b0;
    pc_sel_redirect = 1'b0;
    if_id_en        = 1'b0;
    id_ex_en        = 1'b0;
    ex_mem_en       = 1'b0;
    mem_wb_en       = 1'b0;
    if_id_vin       = 1'b0;
    id_ex_vin       = 1'b0;
    ex_mem_vin      = 1'b0;
    mem_wb_vin      = 1'b0;
    if (rstn) begin
      if (w_freeze) begin
        mem_wb_en = 1'b1;
      end else if (w_redirect) begin
        pc_en           = 1'b1;
        pc_sel_redirect = 1'b1;
        if_id_en        = 1'b1;
        id_ex_en        = 1'b1;
        ex_mem_en       = 1'b1;
        ex_mem_vin      = r_v_ex;
        mem_wb_en       = 1'b1;
        mem_wb_vin      = r_v_mem;
      end else if (w_load_use) begin
        id_ex_en   = 1'b1;
        ex_mem_en  = 1'b1;
        ex_mem_vin = r_v_ex;
        mem_wb_en  = 1'b1;
        mem_wb_vin = r_v_mem;
      end else begin
        pc_en      = w_fetch_ok;
        if_id_en   = 1'b1;
        if_id_vin  = w_fetch_ok;
        id_ex_en   = 1'b1;
        id_ex_vin  = r_v_id;
        ex_mem_en  = 1'b1;
        ex_mem_vin = r_v_ex;
        mem_wb_en  = 1'b1;
        mem_wb_vin = r_v_mem;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_v_id  <= 1'b0;
      r_v_ex  <= 1'b0;
      r_v_mem <= 1'b0;
      r_v_wb  <= 1'b0;
    end else begin
      if (if_id_en)  r_v_id  <= if_id_vin;
      if (id_ex_en)  r_v_ex  <= id_ex_vin;
      if (ex_mem_en) r_v_mem <= ex_mem_vin;
      if (mem_wb_en) r_v_wb  <= mem_wb_vin;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_stall_cnt <= sat_inc(r_stall_cnt, w_freeze | w_load_use);
      r_flush_cnt <= sat_inc(r_flush_cnt, w_redirect);
    end
  end

  assign v_id      = r_v_id;
  assign v_ex      = r_v_ex;
  assign v_mem     = r_v_mem;
  assign v_wb      = r_v_wb;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule
